// File: rtl/uart_echo_fifo_if.sv
// rtl/uart_echo_fifo_if.sv - serial lines, control and status of the UART echo FIFO
// slave is the echo block, master is whatever drives RXD and watches TXD.
interface uart_echo_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  logic                          RXD;
  logic [15:0]                   baudselect;
  logic                          tx_enable;
  logic                          clear_err;
  logic                          TXD;
  logic                          rx_valid;
  logic                          tx_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          frame_err;
  logic                          parity_err;

  modport slave (
    input  RXD, baudselect, tx_enable, clear_err,
    output TXD, rx_valid, tx_busy, fifo_count, overflow, frame_err, parity_err
  );

  modport master (
    output RXD, baudselect, tx_enable, clear_err,
    input  TXD, rx_valid, tx_busy, fifo_count, overflow, frame_err, parity_err
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - UART receiver feeding a FIFO that drains into a UART transmitter
// Define UART_ECHO_PARITY_EN for an even parity bit on both lines.
module uart_echo_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_echo_fifo_if.slave io_bus
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_ECHO_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic                 r_rxd_meta, r_rxd_sync, r_rxd_prev;
  state_t               r_rx_state;
  logic [15:0]          r_rx_baud, r_rx_cnt;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_hold;

  state_t               r_tx_state;
  logic [15:0]          r_tx_baud, r_tx_cnt;
  logic [3:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_txd, r_tx_busy;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_rx_valid, r_overflow, r_frame_err;

  logic [15:0]          w_baud_eff;
  logic                 w_rx_tick, w_stop_sample, w_push, w_frame_evt, w_par_ok;
  logic                 w_full, w_wr, w_pop, w_tx_last;
  logic [DATA_BITS-1:0] w_tx_data;

  assign w_baud_eff    = (io_bus.baudselect < 16'd2) ? 16'd2 : io_bus.baudselect;
  assign w_rx_tick     = (r_rx_cnt == r_rx_baud - 16'd1);
  assign w_stop_sample = (r_rx_state == S_STOP) && !r_rx_hold && w_rx_tick;
  assign w_push        = w_stop_sample && r_rxd_sync && w_par_ok;
  assign w_frame_evt   = w_stop_sample && !r_rxd_sync;
  assign w_full        = (r_count == CNT_FULL);
  assign w_tx_last     = (r_tx_cnt == r_tx_baud - 16'd1);
  assign w_tx_data     = r_mem[r_rd_ptr];
  // Popping on the last stop cycle lets a waiting byte follow with no idle gap.
  assign w_pop = io_bus.tx_enable && (r_count != '0) &&
                 ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_last));
  assign w_wr  = w_push && (!w_full || w_pop);

`ifdef UART_ECHO_PARITY_EN
  logic r_rx_par_bad, r_tx_par, r_parity_err, w_par_evt;
  assign w_par_evt = (r_rx_state == S_PARITY) && w_rx_tick && (r_rxd_sync != ^r_rx_shift);
  assign w_par_ok  = !r_rx_par_bad;
  assign io_bus.parity_err = r_parity_err;
`else
  assign w_par_ok  = 1'b1;
  assign io_bus.parity_err = 1'b0;
`endif

  // Sync flops reset low so a start edge seen before release is ignored until RXD goes high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd_meta <= 1'b0;
      r_rxd_sync <= 1'b0;
      r_rxd_prev <= 1'b0;
    end else begin
      r_rxd_meta <= io_bus.RXD;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= S_IDLE;
      r_rx_baud  <= 16'd2;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_hold  <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      r_rx_par_bad <= 1'b0;
`endif
    end else begin
      case (r_rx_state)
        S_IDLE: if (!r_rxd_sync && r_rxd_prev) begin
          r_rx_state <= S_START;
          r_rx_baud  <= w_baud_eff;
          r_rx_cnt   <= '0;
        end
        S_START: if (r_rx_cnt == (r_rx_baud >> 1) - 16'd1) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rxd_sync ? S_IDLE : S_DATA;
`ifdef UART_ECHO_PARITY_EN
          r_rx_par_bad <= 1'b0;
`endif
        end else begin
          r_rx_cnt <= r_rx_cnt + 16'd1;
        end
        S_DATA: if (w_rx_tick) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rxd_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
            r_rx_state <= S_PARITY;
`else
            r_rx_state <= S_STOP;
`endif
          end else begin
            r_rx_bit <= r_rx_bit + 4'd1;
          end
        end else begin
          r_rx_cnt <= r_rx_cnt + 16'd1;
        end
`ifdef UART_ECHO_PARITY_EN
        S_PARITY: if (w_rx_tick) begin
          r_rx_cnt     <= '0;
          r_rx_par_bad <= w_par_evt;
          r_rx_state   <= S_STOP;
        end else begin
          r_rx_cnt <= r_rx_cnt + 16'd1;
        end
`endif
        S_STOP: if (r_rx_hold) begin
          if (r_rxd_sync) begin
            r_rx_hold  <= 1'b0;
            r_rx_state <= S_IDLE;
          end
        end else if (w_rx_tick) begin
          r_rx_cnt <= '0;
          if (r_rxd_sync) r_rx_state <= S_IDLE;
          else            r_rx_hold  <= 1'b1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 16'd1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_wr && w_pop) r_count <= r_count - CNT_ONE;
      r_rx_valid <= w_wr;
      // A new error event outranks a simultaneous clear.
      if (w_push && !w_wr)       r_overflow <= 1'b1;
      else if (io_bus.clear_err) r_overflow <= 1'b0;
      if (w_frame_evt)           r_frame_err <= 1'b1;
      else if (io_bus.clear_err) r_frame_err <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      if (w_par_evt)             r_parity_err <= 1'b1;
      else if (io_bus.clear_err) r_parity_err <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_baud  <= 16'd2;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else if (w_pop) begin
      r_tx_state <= S_START;
      r_tx_baud  <= w_baud_eff;
      r_tx_cnt   <= '0;
      r_tx_shift <= w_tx_data;
      r_txd      <= 1'b0;
      r_tx_busy  <= 1'b1;
`ifdef UART_ECHO_PARITY_EN
      r_tx_par   <= ^w_tx_data;
`endif
    end else begin
      case (r_tx_state)
        S_START: if (w_tx_last) begin
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_txd      <= r_tx_shift[0];
          r_tx_state <= S_DATA;
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
        S_DATA: if (w_tx_last) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
            r_txd      <= r_tx_par;
            r_tx_state <= S_PARITY;
`else
            r_txd      <= 1'b1;
            r_tx_state <= S_STOP;
`endif
          end else begin
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx_shift <= r_tx_shift >> 1;
            r_txd      <= r_tx_shift[1];
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
`ifdef UART_ECHO_PARITY_EN
        S_PARITY: if (w_tx_last) begin
          r_tx_cnt   <= '0;
          r_txd      <= 1'b1;
          r_tx_state <= S_STOP;
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
`endif
        S_STOP: if (w_tx_last) begin
          r_tx_cnt   <= '0;
          r_tx_busy  <= 1'b0;
          r_tx_state <= S_IDLE;
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.TXD        = r_txd;
  assign io_bus.rx_valid   = r_rx_valid;
  assign io_bus.tx_busy    = r_tx_busy;
  assign io_bus.fifo_count = r_count;
  assign io_bus.overflow   = r_overflow;
  assign io_bus.frame_err  = r_frame_err;
endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, echo buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RXD  input  1  serial receive line, asynchronous to clk, idle high.
REQ-006 SHALL have port baudselect  input  16  clk cycles per bit.
REQ-007 SHALL have port tx_enable  input  1  1 = FIFO drains to TXD; 0 = echo paused, bytes held.
REQ-008 SHALL have port clear_err  input  1  one-cycle pulse clearing sticky error flags.
REQ-009 SHALL have port TXD  output  1  serial transmit line, idle high.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse per byte accepted into FIFO.
REQ-011 SHALL have port tx_busy  output  1  high while a frame is on TXD.
REQ-012 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently buffered.
REQ-013 SHALL have ports overflow, frame_err, parity_err  output  1 each  sticky error flags.

Function
REQ-014 RXD SHALL pass a 2-flop synchronizer before use; all RX timing counts from the synchronized signal.
REQ-015 Receiver states SHALL be IDLE, START, DATA, PARITY, STOP; falling edge in IDLE -> START.
REQ-016 START SHALL wait baudselect/2 cycles and re-sample; high -> IDLE (glitch rejected, nothing pushed), low -> DATA.
REQ-017 DATA SHALL sample every baudselect cycles, LSB first, DATA_BITS samples, then PARITY (if compiled) or STOP.
REQ-018 STOP sample high SHALL push the byte to the FIFO and pulse rx_valid the following cycle; sample low SHALL set frame_err, drop the byte, and hold the receiver until RXD high before IDLE.
REQ-019 baudselect SHALL be latched at each frame start (RX and TX independently); values below 2 SHALL be treated as 2.
REQ-020 FIFO push when full SHALL drop the byte and set overflow, no rx_valid; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-021 FIFO order SHALL be strictly first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 Transmitter states SHALL be IDLE, START, DATA, PARITY, STOP; in IDLE with tx_enable=1 and fifo_count>0 it SHALL pop one byte and enter START next cycle.
REQ-023 Each TX bit SHALL last exactly baudselect cycles; TXD order: 0 start, data LSB first, parity (if compiled), 1 stop.
REQ-024 tx_busy SHALL rise in the pop cycle and fall after the final stop cycle; a waiting byte SHALL start the next start bit with at most one idle cycle gap.
REQ-025 tx_enable deasserted mid-frame SHALL NOT abort the current frame; it only blocks the next pop.
REQ-026 clear_err SHALL clear overflow, frame_err, parity_err; a set event in the same cycle SHALL win.

Reset
REQ-027 On reset assertion, immediately and independent of clk: TXD=1, rx_valid=0, tx_busy=0, fifo_count=0, all error flags 0, both FSMs IDLE, FIFO pointers 0.
REQ-028 Reset mid-frame SHALL discard partial RX byte and abort TX frame; buffered data SHALL be lost.
REQ-029 After reset release, a frame whose start edge preceded release SHALL NOT be received until RXD has been high for one cycle.

Configuration
REQ-030 Macro UART_ECHO_PARITY_EN defined: even parity bit SHALL follow data on RX and TX; RX parity mismatch SHALL set parity_err and drop the byte.
REQ-031 Macro UART_ECHO_PARITY_EN undefined: no parity bit on either line, PARITY states absent, parity_err tied 0.

Verification
REQ-032 baudselect=4, tx_enable=1, receive 0xA5 -> one rx_valid pulse; TXD emits 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit; fifo_count returns 0.
REQ-033 FIFO_DEPTH=16, tx_enable=0, receive 17 bytes 0x00..0x10 -> fifo_count=16, overflow=1, 16 rx_valid pulses; set tx_enable=1 -> TXD echoes 0x00..0x0F in order, back-to-back.
REQ-034 Receive frame with stop bit 0 -> frame_err=1, fifo_count unchanged; clear_err pulse -> frame_err=0.
REQ-035 RXD low for 1 cycle at baudselect=8 -> no rx_valid, receiver back in IDLE.
REQ-036 Assert reset mid-TX data bit with 3 bytes buffered -> TXD=1, tx_busy=0, fifo_count=0 same cycle as reset.
REQ-037 With UART_ECHO_PARITY_EN, receive 0x03 with parity bit 1 -> parity_err=1, byte not echoed; with parity bit 0 -> echoed with parity 0.
